// File: rtl/usb_nrzi_tx.sv
// usb_nrzi_tx: NRZI line encoder and EOP generator for the USB transmit path.
// Consumes the stuffed bitstream from the bit stuffer, drives dp/dm/bus_en
// and reports packet completion and dropped bits.
// Optional feature macro: USB_NRZI_EOP_J_EN (actively drive J as the final
// EOP bit time; when undefined the bus is released straight after SE0,SE0).
module usb_nrzi_tx (
    input  logic clock,
    input  logic reset,
    input  logic in_bit,
    input  logic bs_sending,
    output logic dp,
    output logic dm,
    output logic bus_en,
    output logic nrzi_ready,
    output logic nrzi_done,
    output logic nrzi_err
);

    // Line level encoding for line_q: 1 = J, 0 = K.
    localparam logic LINE_J = 1'b1;

`ifdef USB_NRZI_EOP_J_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        EOP_SE0_A = 3'd2,
        EOP_SE0_B = 3'd3,
        EOP_J     = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        EOP_SE0_A = 3'd2,
        EOP_SE0_B = 3'd3
    } state_t;
`endif

    state_t state_q, state_d;
    logic   line_q, line_d;
    logic   dp_q, dp_d;
    logic   dm_q, dm_d;
    logic   bus_en_q, bus_en_d;
    logic   done_q, done_d;
    logic   err_q, err_d;

    // Next-state and NRZI encoding: a 0 toggles the line, a 1 holds it.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                line_d = LINE_J;
                if (bs_sending) begin
                    line_d  = in_bit ? LINE_J : ~LINE_J;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bs_sending) begin
                    line_d = in_bit ? line_q : ~line_q;
                end else begin
                    state_d = EOP_SE0_A;
                end
            end
            EOP_SE0_A: begin
                err_d   = bs_sending;
                state_d = EOP_SE0_B;
            end
            EOP_SE0_B: begin
                err_d = bs_sending;
`ifdef USB_NRZI_EOP_J_EN
                state_d = EOP_J;
`else
                state_d = IDLE;
                line_d  = LINE_J;
`endif
            end
`ifdef USB_NRZI_EOP_J_EN
            EOP_J: begin
                err_d   = bs_sending;
                state_d = IDLE;
                line_d  = LINE_J;
            end
`endif
            default: begin
                state_d = IDLE;
                line_d  = LINE_J;
            end
        endcase
    end

    // Output decode from the upcoming state so dp/dm/bus_en/done can be registered.
    always_comb begin
        dp_d     = 1'b1;
        dm_d     = 1'b0;
        bus_en_d = 1'b1;
        done_d   = 1'b0;
        case (state_d)
            IDLE: begin
                bus_en_d = 1'b0;
            end
            SEND: begin
                dp_d = line_d;
                dm_d = ~line_d;
            end
            EOP_SE0_A: begin
                dp_d = 1'b0;
                dm_d = 1'b0;
            end
            EOP_SE0_B: begin
                dp_d = 1'b0;
                dm_d = 1'b0;
`ifndef USB_NRZI_EOP_J_EN
                done_d = 1'b1;
`endif
            end
`ifdef USB_NRZI_EOP_J_EN
            EOP_J: begin
                done_d = 1'b1;
            end
`endif
            default: begin
                bus_en_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any packet and idles the line at J.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            line_q   <= LINE_J;
            dp_q     <= 1'b1;
            dm_q     <= 1'b0;
            bus_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            dp_q     <= dp_d;
            dm_q     <= dm_d;
            bus_en_q <= bus_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign dp         = dp_q;
    assign dm         = dm_q;
    assign bus_en     = bus_en_q;
    assign nrzi_done  = done_q;
    assign nrzi_err   = err_q;
    assign nrzi_ready = (state_q == IDLE);

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// tb_usb_nrzi_tx: self-checking bench for usb_nrzi_tx. A packet-level model
// turns a list of data bits into the expected per-cycle line waveform.
module tb_usb_nrzi_tx;

    logic clock = 1'b0;
    logic reset;
    logic in_bit;
    logic bs_sending;
    logic dp, dm, bus_en, nrzi_ready, nrzi_done, nrzi_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic dp;
        logic dm;
        logic en;
        logic rdy;
        logic done;
        logic err;
    } sample_t;

    bit      pkt[$];
    sample_t expQ[$];
    sample_t obsQ[$];

    usb_nrzi_tx dut (
        .clock      (clock),
        .reset      (reset),
        .in_bit     (in_bit),
        .bs_sending (bs_sending),
        .dp         (dp),
        .dm         (dm),
        .bus_en     (bus_en),
        .nrzi_ready (nrzi_ready),
        .nrzi_done  (nrzi_done),
        .nrzi_err   (nrzi_err)
    );

    // Free-running bit clock.
    always #5 clock = ~clock;

`ifdef USB_NRZI_EOP_J_EN
    localparam int EOP_LEN = 3;
`else
    localparam int EOP_LEN = 2;
`endif

    localparam sample_t IDLE_S = sample_t'{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    function automatic sample_t sampleNow();
        return sample_t'({dp, dm, bus_en, nrzi_ready, nrzi_done, nrzi_err});
    endfunction

    // Expected waveform: one sample per data bit, the EOP, one idle sample, then gap idles.
    task automatic modelPacket(input int abuseOff, input int gap);
        logic    line;
        sample_t s;
        expQ.delete();
        line = 1'b1;
        foreach (pkt[i]) begin
            if (pkt[i] == 1'b0) line = ~line;
            expQ.push_back(sample_t'{line, ~line, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        for (int e = 0; e < EOP_LEN; e++) begin
            if (e < 2) s = sample_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            else       s = sample_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            if (e == EOP_LEN - 1) s.done = 1'b1;
            expQ.push_back(s);
        end
        for (int g = 0; g <= gap; g++) expQ.push_back(IDLE_S);
        if (abuseOff > 0) begin
            s = expQ[pkt.size() + abuseOff];
            s.err = 1'b1;
            expQ[pkt.size() + abuseOff] = s;
        end
    endtask

    // Drives the packet (plus optional stray bs_sending during the EOP) and records outputs.
    task automatic drivePacket(input int abuseOff);
        obsQ.delete();
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < pkt.size()) begin
                bs_sending = 1'b1;
                in_bit     = pkt[i];
            end else begin
                bs_sending = (abuseOff > 0) && (i == pkt.size() + abuseOff);
                in_bit     = 1'($urandom);
            end
            @(posedge clock);
            #1;
            obsQ.push_back(sampleNow());
        end
        bs_sending = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bs_sending = 1'b0;
        in_bit     = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock);
            #1;
            checks++;
            if (sampleNow() !== IDLE_S) begin
                errors++;
                $display("[TB] FAIL reset[%0d] {dp,dm,en,rdy,done,err} got %b want %b", c, sampleNow(), IDLE_S);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_sync();
        pkt = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        modelPacket(0, 1);
        drivePacket(0);
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL sync[%0d] {dp,dm,en,rdy,done,err} got %b want %b", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        pkt = '{0, 1, 1};
        modelPacket(0, 0);
        drivePacket(0);
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL b2b_first[%0d] {dp,dm,en,rdy,done,err} got %b want %b", i, obsQ[i], expQ[i]);
            end
        end
        pkt = '{0, 1};
        modelPacket(0, 1);
        drivePacket(0);
        checks++;
        if ({obsQ[0].dp, obsQ[0].dm} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL b2b_restart_K {dp,dm} got %b want 01", {obsQ[0].dp, obsQ[0].dm});
        end
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL b2b_second[%0d] {dp,dm,en,rdy,done,err} got %b want %b", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_abuse();
        pkt.delete();
        for (int b = 0; b < 5; b++) pkt.push_back(1'($urandom));
        modelPacket(2, 2);
        drivePacket(2);
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL abuse[%0d] {dp,dm,en,rdy,done,err} got %b want %b", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic line;
        pkt.delete();
        for (int b = 0; b < 8; b++) pkt.push_back(1'($urandom));
        line = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bs_sending = 1'b1;
            in_bit     = pkt[i];
            if (pkt[i] == 1'b0) line = ~line;
            @(posedge clock);
            #1;
            checks++;
            if ({dp, dm, bus_en} !== {line, ~line, 1'b1}) begin
                errors++;
                $display("[TB] FAIL midrst_bit[%0d] {dp,dm,en} got %b want %b", i, {dp, dm, bus_en}, {line, ~line, 1'b1});
            end
        end
        reset      = 1'b1;
        in_bit     = pkt[4];
        @(posedge clock);
        #1;
        reset      = 1'b0;
        bs_sending = 1'b0;
        checks++;
        if (sampleNow() !== IDLE_S) begin
            errors++;
            $display("[TB] FAIL midrst_abort {dp,dm,en,rdy,done,err} got %b want %b", sampleNow(), IDLE_S);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            checks++;
            if (sampleNow() !== IDLE_S) begin
                errors++;
                $display("[TB] FAIL midrst_idle[%0d] {dp,dm,en,rdy,done,err} got %b want %b", c, sampleNow(), IDLE_S);
            end
        end
        modelPacket(0, 0);
        drivePacket(0);
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL midrst_after[%0d] {dp,dm,en,rdy,done,err} got %b want %b", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_random();
        int len, gap, abuse;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 24);
            gap = $urandom_range(0, 2);
            abuse = ($urandom_range(0, 3) == 0) ? $urandom_range(1, EOP_LEN) : 0;
            if (abuse >= EOP_LEN + 1) abuse = EOP_LEN;
            pkt.delete();
            for (int b = 0; b < len; b++) pkt.push_back(1'($urandom));
            modelPacket(abuse, gap);
            drivePacket(abuse);
            foreach (expQ[i]) begin
                checks++;
                if (obsQ[i] !== expQ[i]) begin
                    errors++;
                    $display("[TB] FAIL rand%0d[%0d] len=%0d abuse=%0d {dp,dm,en,rdy,done,err} got %b want %b",
                             p, i, len, abuse, obsQ[i], expQ[i]);
                end
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_sync();
        test_back_to_back();
        test_abuse();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
